// File: rtl/bp_fe_queue_buffer.sv
// FE queue buffer: FIFO between the PC generator and the BE issue stage.
// The BE consumes speculatively (yumi) and later commits (deq) or replays (roll).
// Three pointers carry a wrap bit: write, read (speculative head) and commit.
module bp_fe_queue_buffer #(
   parameter int  els_p            = 8,
   parameter int  fe_queue_width_p = 128,
   localparam int ptr_width_lp     = $clog2(els_p) + 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        clr_v_i,
   input  logic [fe_queue_width_p-1:0] fe_queue_i,
   input  logic                        fe_queue_v_i,
   output logic                        fe_queue_ready_o,
   output logic [fe_queue_width_p-1:0] fe_queue_o,
   output logic                        fe_queue_v_o,
   input  logic                        fe_queue_yumi_i,
   input  logic                        fe_queue_deq_i,
   input  logic                        fe_queue_roll_i,
   output logic [ptr_width_lp-1:0]     count_o
);

   localparam int                    IDX_W  = ptr_width_lp - 1;
   localparam logic [ptr_width_lp-1:0] LP_ELS = ptr_width_lp'(els_p);

   logic [fe_queue_width_p-1:0] r_mem [els_p];
   logic [ptr_width_lp-1:0]     r_wptr, r_rptr, r_cptr;
   logic [ptr_width_lp-1:0]     w_wptr_n, w_rptr_n, w_cptr_n;
   logic                        w_full, w_v, w_enq, w_yumi, w_deq;

   // Occupancy is measured against the commit pointer: consumed-but-uncommitted
   // entries still hold their slots so they can be replayed.
   assign w_full = (r_wptr - r_cptr) == LP_ELS;
   assign w_v    = (r_wptr != r_rptr);
   assign w_enq  = fe_queue_v_i & ~w_full;
   assign w_yumi = fe_queue_yumi_i & w_v;
   assign w_deq  = fe_queue_deq_i & (r_cptr != r_rptr);

   assign fe_queue_ready_o = ~w_full;
   assign fe_queue_v_o     = w_v;
   assign fe_queue_o       = r_mem[r_rptr[IDX_W-1:0]];
   assign count_o          = r_wptr - r_rptr;

   // Next pointers: clr wins over everything, roll overrides the same-cycle yumi
   // but still sees a same-cycle commit.
   always_comb begin
      w_wptr_n = r_wptr + ptr_width_lp'(w_enq);
      w_cptr_n = r_cptr + ptr_width_lp'(w_deq);
      w_rptr_n = r_rptr + ptr_width_lp'(w_yumi);
      if (fe_queue_roll_i) w_rptr_n = w_cptr_n;
      if (clr_v_i) begin
         w_wptr_n = '0;
         w_rptr_n = '0;
         w_cptr_n = '0;
      end
   end

   // Pointer registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cptr <= '0;
      end else begin
         r_wptr <= w_wptr_n;
         r_rptr <= w_rptr_n;
         r_cptr <= w_cptr_n;
      end
   end

   // Storage; reset so the head output reads zero out of reset, not cleared by clr
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
      end else if (w_enq && !clr_v_i) begin
         r_mem[r_wptr[IDX_W-1:0]] <= fe_queue_i;
      end
   end

   // A consume with nothing readable is a BE protocol error; it is dropped above
   always_ff @(posedge clk_i) begin
      if (reset_n_i && fe_queue_yumi_i) assert (w_v);
   end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Bench for bp_fe_queue_buffer: directed scenarios plus a random phase, all
// checked against a queue scoreboard holding uncommitted messages in order.
module tb_bp_fe_queue_buffer;

   localparam int W = 128;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic         clr_v_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i;
   logic [W-1:0] fe_queue_i;
   logic         fe_queue_ready_o, fe_queue_v_o;
   logic [W-1:0] fe_queue_o;
   logic [3:0]   count_o;

   bp_fe_queue_buffer #(.els_p(8), .fe_queue_width_p(W)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_v_i(clr_v_i),
      .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
      .fe_queue_ready_o(fe_queue_ready_o), .fe_queue_o(fe_queue_o),
      .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
      .fe_queue_deq_i(fe_queue_deq_i), .fe_queue_roll_i(fe_queue_roll_i),
      .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: sb holds messages from the commit point onward; rd is the
   // speculative read offset into it.
   logic [W-1:0] sb[$];
   int           rd;
   int           n_chk  = 0;
   int           n_fail = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("ready", W'(fe_queue_ready_o), W'(sb.size() != 8));
      chk("valid", W'(fe_queue_v_o), W'(rd < sb.size()));
      chk("count", W'(count_o), W'(sb.size() - rd));
      if (rd < sb.size()) chk("data", fe_queue_o, sb[rd]);
   endtask

   // Apply the model for the inputs currently driven, clock once, then check.
   task automatic cyc();
      bit e, y, d;
      if (clr_v_i) begin
         sb.delete();
         rd = 0;
      end else begin
         e = fe_queue_v_i && (sb.size() != 8);
         y = fe_queue_yumi_i && (rd < sb.size());
         d = fe_queue_deq_i && (rd > 0);
         if (d) begin
            void'(sb.pop_front());
            rd--;
         end
         if (y && !fe_queue_roll_i) rd++;
         if (fe_queue_roll_i) rd = 0;
         if (e) sb.push_back(fe_queue_i);
      end
      @(posedge clk_i);
      #1;
      chk_all();
   endtask

   task automatic step(input logic e, input logic [W-1:0] dat, input logic y,
                       input logic dq, input logic rl, input logic cl);
      fe_queue_v_i    = e;
      fe_queue_i      = dat;
      fe_queue_yumi_i = y;
      fe_queue_deq_i  = dq;
      fe_queue_roll_i = rl;
      clr_v_i         = cl;
      cyc();
   endtask

   initial begin
      reset_n_i = 1'b0;
      clr_v_i = 0; fe_queue_v_i = 0; fe_queue_yumi_i = 0; fe_queue_deq_i = 0;
      fe_queue_roll_i = 0; fe_queue_i = '0;
      sb.delete();
      rd = 0;
      #1;
      chk("rst_v", W'(fe_queue_v_o), '0);
      chk("rst_ready", W'(fe_queue_ready_o), W'(1));
      chk("rst_count", W'(count_o), '0);
      chk("rst_data", fe_queue_o, '0);
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;

      // Reset mid-traffic: outputs return to reset values without a clock edge
      step(1, W'(8'h55), 0, 0, 0, 0);
      step(1, W'(8'h66), 1, 0, 0, 0);
      fe_queue_yumi_i = 1'b1;
      #2 reset_n_i = 1'b0;
      #1;
      chk("mid_rst_v", W'(fe_queue_v_o), '0);
      chk("mid_rst_ready", W'(fe_queue_ready_o), W'(1));
      chk("mid_rst_count", W'(count_o), '0);
      chk("mid_rst_data", fe_queue_o, '0);
      sb.delete();
      rd = 0;
      fe_queue_v_i = 0; fe_queue_yumi_i = 0;
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;

      // Fill to capacity; a ninth enqueue is dropped
      for (int i = 0; i < 8; i++) step(1, W'(8'h10 + i), 0, 0, 0, 0);
      chk("full_ready", W'(fe_queue_ready_o), '0);
      chk("full_count", W'(count_o), W'(8));
      step(1, W'(8'h99), 0, 0, 0, 0);
      chk("ovf_count", W'(count_o), W'(8));
      for (int i = 0; i < 8; i++) begin
         chk("fill_order", fe_queue_o, W'(8'h10 + i));
         step(0, '0, 1, 0, 0, 0);
      end
      chk("drained_v", W'(fe_queue_v_o), '0);
      chk("drained_ready", W'(fe_queue_ready_o), '0);

      // Commit frees slots; new entries wrap into slots 0..2
      step(0, '0, 0, 1, 0, 0);
      chk("deq_ready", W'(fe_queue_ready_o), W'(1));
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, W'(8'h18 + i), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("wrap_order", fe_queue_o, W'(8'h18 + i));
         step(0, '0, 1, 0, 0, 0);
      end
      for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 0, 0);
      chk("commit_empty", W'(count_o), '0);

      // Roll back to the commit point after one commit
      step(1, W'(8'hA), 0, 0, 0, 0);
      step(1, W'(8'hB), 0, 0, 0, 0);
      step(1, W'(8'hC), 0, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 0, 1, 0);
      chk("roll_head", fe_queue_o, W'(8'hB));
      chk("roll_count", W'(count_o), W'(2));

      // Roll with yumi and enqueue in one cycle, then clr with enqueue
      step(1, W'(8'hD), 1, 0, 1, 0);
      chk("ryq_head", fe_queue_o, W'(8'hB));
      chk("ryq_count", W'(count_o), W'(3));
      step(1, W'(8'hE), 0, 0, 0, 1);
      chk("clr_v", W'(fe_queue_v_o), '0);
      chk("clr_count", W'(count_o), '0);
      chk("clr_ready", W'(fe_queue_ready_o), W'(1));
      step(1, W'(8'hF), 0, 0, 0, 0);
      chk("post_clr_head", fe_queue_o, W'(8'hF));

      // Random traffic; yumi and deq only issued when legal
      for (int c = 0; c < 10000; c++) begin
         step(($urandom_range(0, 3) != 0),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 2) != 0) && (rd < sb.size()),
              ($urandom_range(0, 2) != 0) && (rd > 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 63) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
